// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide memory responder: width codes, FSM states, RAM levels.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Width code 11 is folded into a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            MEM_BYTE: byte_count = 3'd1;
            MEM_HALF: byte_count = 3'd2;
            default:  byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch/data requester handshakes plus the byte-wide RAM port seen by mem_ctrl.
// slave = the controller itself, master = requesters and RAM.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_cancel_i;
    logic [DATA_WIDTH-1:0] if_inst_o;
    logic                  if_done_o;

    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [1:0]            mem_width_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0] mem_wdata_i;
    logic [DATA_WIDTH-1:0] mem_rdata_o;
    logic                  mem_done_o;
    logic                  mem_busy_o;

    logic [ADDR_WIDTH-1:0] ram_a_o;
    logic [7:0]            ram_dout_o;
    logic [7:0]            ram_din_i;
    logic                  ram_wr_o;

    modport slave (
        input  if_req_i, if_addr_i, if_cancel_i,
        output if_inst_o, if_done_o,
        input  mem_req_i, mem_we_i, mem_width_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_done_o, mem_busy_o,
        output ram_a_o, ram_dout_o, ram_wr_o,
        input  ram_din_i
    );

    modport master (
        output if_req_i, if_addr_i, if_cancel_i,
        input  if_inst_o, if_done_o,
        output mem_req_i, mem_we_i, mem_width_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_done_o, mem_busy_o,
        input  ram_a_o, ram_dout_o, ram_wr_o,
        output ram_din_i
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch vs data requests onto a byte-wide RAM; data wins, one byte per cycle.
// Done pulses N cycles after accept; an idle cycle follows each completion before the next accept.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [2:0]            r_n;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic [7:0]            r_ram_dout;
    logic                  r_ram_wr;
    logic [DATA_WIDTH-1:0] r_if_inst;
    logic [DATA_WIDTH-1:0] r_mem_rdata;
    logic                  r_if_done;
    logic                  r_mem_done;

    logic [2:0]            w_cnt_nxt;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_asm;
    logic [7:0]            w_wbyte;

    assign w_cnt_nxt  = r_cnt + 3'd1;
    assign w_last     = (w_cnt_nxt == r_n);
    assign w_addr_nxt = r_addr + ADDR_WIDTH'(w_cnt_nxt);

    // The byte arriving now belongs to the address issued one cycle ago, i.e. lane r_cnt.
    always_comb begin
        w_asm = r_buf;
        case (r_cnt[1:0])
            2'd0:    w_asm[7:0]   = bus.ram_din_i;
            2'd1:    w_asm[15:8]  = bus.ram_din_i;
            2'd2:    w_asm[23:16] = bus.ram_din_i;
            default: w_asm[31:24] = bus.ram_din_i;
        endcase
    end

    always_comb begin
        case (w_cnt_nxt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= RAM_READ;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req_i) begin
                        r_addr  <= bus.mem_addr_i;
                        r_n     <= byte_count(bus.mem_width_i);
                        r_wdata <= bus.mem_wdata_i;
                        r_cnt   <= '0;
                        r_buf   <= '0;
                        r_ram_a <= bus.mem_addr_i;
                        if (bus.mem_we_i) begin
                            r_ram_dout <= bus.mem_wdata_i[7:0];
                            r_ram_wr   <= RAM_WRITE;
                            r_state    <= ST_MEM_WR;
                        end else begin
                            r_state    <= ST_MEM_RD;
                        end
                    end else if (bus.if_req_i && !bus.if_cancel_i) begin
                        r_addr  <= bus.if_addr_i;
                        r_n     <= 3'd4;
                        r_cnt   <= '0;
                        r_buf   <= '0;
                        r_ram_a <= bus.if_addr_i;
                        r_state <= ST_IF_RD;
                    end
                end
                ST_IF_RD: begin
                    if (bus.if_cancel_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_buf <= w_asm;
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_if_inst <= w_asm;
                            r_if_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_ram_a <= w_addr_nxt;
                        end
                    end
                end
                ST_MEM_RD: begin
                    r_buf <= w_asm;
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_mem_rdata <= w_asm;
                        r_mem_done  <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_ram_a <= w_addr_nxt;
                    end
                end
                ST_MEM_WR: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_ram_wr   <= RAM_READ;
                        r_mem_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_ram_a    <= w_addr_nxt;
                        r_ram_dout <= w_wbyte;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_inst_o   = r_if_inst;
    assign bus.if_done_o   = r_if_done;
    assign bus.mem_rdata_o = r_mem_rdata;
    assign bus.mem_done_o  = r_mem_done;
    assign bus.ram_a_o     = r_ram_a;
    assign bus.ram_dout_o  = r_ram_dout;
    assign bus.ram_wr_o    = r_ram_wr;
    // Combinational so the stall controller freezes fetch in the same cycle the request rises.
    assign bus.mem_busy_o  = bus.mem_req_i | (r_state == ST_MEM_RD) | (r_state == ST_MEM_WR);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model plus a byte-array reference of memory contents.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
    mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] trace_q [$];
    int total = 0;
    int bad   = 0;

    assign bus.ram_din_i = ram[bus.ram_a_o[15:0]];
    always @(posedge clk) if (bus.ram_wr_o) ram[bus.ram_a_o[15:0]] <= bus.ram_dout_o;

    function automatic int nb(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[16'(a + 32'(i))];
        return v;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a[15:0]] = d;
        ref_mem[a[15:0]] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_fetch(input logic [31:0] addr, output logic [31:0] inst, output int lat,
                             output logic tmo);
        trace_q.delete();
        bus.if_addr_i = addr;
        bus.if_req_i  = 1'b1;
        tmo = 1'b1; inst = 0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.if_done_o) begin inst = bus.if_inst_o; lat = i - 1; tmo = 1'b0; break; end
            trace_q.push_back(bus.ram_a_o);
        end
        bus.if_req_i = 1'b0;
        tick();
    endtask

    task automatic run_mem(input logic we, input logic [1:0] width, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                           output int wr_cnt, output int busy_low, output logic tmo);
        trace_q.delete();
        bus.mem_we_i = we; bus.mem_width_i = width; bus.mem_addr_i = addr;
        bus.mem_wdata_i = wdata; bus.mem_req_i = 1'b1;
        tmo = 1'b1; rdata = 0; lat = 0; wr_cnt = 0; busy_low = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!bus.mem_busy_o) busy_low++;
            if (bus.mem_done_o) begin rdata = bus.mem_rdata_o; lat = i - 1; tmo = 1'b0; break; end
            if (bus.ram_wr_o) wr_cnt++;
            trace_q.push_back(bus.ram_a_o);
        end
        bus.mem_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_cancel_i = 0;
        bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_width_i = 0;
        bus.mem_addr_i = 0; bus.mem_wdata_i = 0;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (bus.if_done_o !== 1'b0) begin bad++; $display("FAIL reset_if_done got=%b want=0", bus.if_done_o); end
        total++; if (bus.mem_done_o !== 1'b0) begin bad++; $display("FAIL reset_mem_done got=%b want=0", bus.mem_done_o); end
        total++; if (bus.ram_wr_o !== 1'b0) begin bad++; $display("FAIL reset_ram_wr got=%b want=0", bus.ram_wr_o); end
        total++; if (bus.ram_a_o !== 32'h0) begin bad++; $display("FAIL reset_ram_a got=%h want=0", bus.ram_a_o); end
        total++; if (bus.if_inst_o !== 32'h0) begin bad++; $display("FAIL reset_if_inst got=%h want=0", bus.if_inst_o); end
        total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.mem_busy_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        logic [31:0] inst; int lat; logic tmo;
        poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        run_fetch(32'h100, inst, lat, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL fetch_timeout got=%b want=0", tmo); end
        total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL fetch_inst got=%h want=00000013", inst); end
        total++; if (lat != 4) begin bad++; $display("FAIL fetch_latency got=%0d want=4", lat); end
        total++;
        if (trace_q.size() != 4) begin bad++; $display("FAIL fetch_trace_len got=%0d want=4", trace_q.size()); end
        else for (int k = 0; k < 4; k++) begin
            total++;
            if (trace_q[k] !== 32'h100 + 32'(k)) begin
                bad++; $display("FAIL fetch_addr_%0d got=%h want=%h", k, trace_q[k], 32'h100 + 32'(k));
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; int lat, wrc, bl; logic tmo;
        logic [31:0] wd = 32'hDEAD_BEEF;
        run_mem(1'b1, MEM_WORD, 32'h200, wd, rd, lat, wrc, bl, tmo);
        for (int i = 0; i < 4; i++) ref_mem[16'h200 + 16'(i)] = wd[8*i +: 8];
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL store_timeout got=%b want=0", tmo); end
        total++; if (wrc != 4) begin bad++; $display("FAIL store_wr_cycles got=%0d want=4", wrc); end
        total++; if (lat != 4) begin bad++; $display("FAIL store_latency got=%0d want=4", lat); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ram[16'h200 + 16'(i)] !== ref_mem[16'h200 + 16'(i)]) begin
                bad++; $display("FAIL store_byte_%0d got=%h want=%h", i, ram[16'h200 + 16'(i)], ref_mem[16'h200 + 16'(i)]);
            end
        end
        run_mem(1'b0, MEM_BYTE, 32'h203, 32'h0, rd, lat, wrc, bl, tmo);
        total++; if (rd !== 32'h0000_00DE) begin bad++; $display("FAIL load_byte got=%h want=000000de", rd); end
        total++; if (lat != 1) begin bad++; $display("FAIL load_byte_latency got=%0d want=1", lat); end
    endtask

    task automatic test_priority();
        logic if_first = 1'b0; logic got = 1'b0; int busy_low = 0; int n = 0;
        logic [31:0] rd = 0;
        bus.if_addr_i = 32'h100; bus.if_req_i = 1'b1;
        bus.mem_we_i = 1'b0; bus.mem_width_i = MEM_HALF; bus.mem_addr_i = 32'h200; bus.mem_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.if_done_o) if_first = 1'b1;
            if (!bus.mem_busy_o) busy_low++;
            if (bus.mem_done_o) begin rd = bus.mem_rdata_o; got = 1'b1; break; end
        end
        bus.mem_req_i = 1'b0;
        #1;
        total++; if (got !== 1'b1) begin bad++; $display("FAIL prio_mem_timeout got=%b want=1", got); end
        total++; if (if_first !== 1'b0) begin bad++; $display("FAIL prio_fetch_first got=%b want=0", if_first); end
        total++; if (rd !== 32'h0000_BEEF) begin bad++; $display("FAIL prio_rdata got=%h want=0000beef", rd); end
        total++; if (busy_low != 0) begin bad++; $display("FAIL prio_busy_low got=%0d want=0", busy_low); end
        total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL prio_busy_after got=%b want=0", bus.mem_busy_o); end
        tick();
        total++; if (bus.ram_a_o !== 32'h201) begin bad++; $display("FAIL prio_no_early_accept got=%h want=00000201", bus.ram_a_o); end
        tick();
        total++; if (bus.ram_a_o !== 32'h100) begin bad++; $display("FAIL prio_fetch_accept got=%h want=00000100", bus.ram_a_o); end
        got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.if_done_o) begin n = i; got = 1'b1; break; end
        end
        total++; if (got !== 1'b1 || n != 4) begin bad++; $display("FAIL prio_fetch_latency got=%0d want=4", n); end
        total++; if (bus.if_inst_o !== ref_read(32'h100, 4)) begin bad++; $display("FAIL prio_fetch_inst got=%h want=%h", bus.if_inst_o, ref_read(32'h100, 4)); end
        bus.if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_cancel();
        logic early_done = 1'b0; logic wr_seen = 1'b0; logic got = 1'b0; int n = 0;
        logic [31:0] w = $urandom() | 32'h1;
        for (int i = 0; i < 4; i++) poke(32'h300 + 32'(i), w[8*i +: 8]);
        bus.if_addr_i = 32'h100; bus.if_req_i = 1'b1;
        tick();
        tick();
        bus.if_cancel_i = 1'b1;
        tick();
        early_done = bus.if_done_o;
        bus.if_cancel_i = 1'b0; bus.if_addr_i = 32'h300;
        tick();
        total++; if (bus.ram_a_o !== 32'h300) begin bad++; $display("FAIL cancel_new_accept got=%h want=00000300", bus.ram_a_o); end
        for (int i = 1; i <= 20; i++) begin
            if (bus.ram_wr_o) wr_seen = 1'b1;
            tick();
            if (bus.if_done_o) begin n = i; got = 1'b1; break; end
        end
        total++; if (early_done !== 1'b0) begin bad++; $display("FAIL cancel_done got=%b want=0", early_done); end
        total++; if (wr_seen !== 1'b0) begin bad++; $display("FAIL cancel_ram_wr got=%b want=0", wr_seen); end
        total++; if (got !== 1'b1 || n != 4) begin bad++; $display("FAIL cancel_refetch_latency got=%0d want=4", n); end
        total++; if (bus.if_inst_o !== w) begin bad++; $display("FAIL cancel_refetch_inst got=%h want=%h", bus.if_inst_o, w); end
        bus.if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] old = $urandom();
        logic [31:0] wd = old ^ 32'hFFFF_FFFF;
        logic done_seen = 1'b0;
        for (int i = 0; i < 4; i++) poke(32'h400 + 32'(i), old[8*i +: 8]);
        bus.mem_we_i = 1'b1; bus.mem_width_i = MEM_WORD; bus.mem_addr_i = 32'h400;
        bus.mem_wdata_i = wd; bus.mem_req_i = 1'b1;
        tick();
        tick();
        rst = 1'b1; bus.mem_req_i = 1'b0;
        tick();
        total++; if (bus.ram_a_o !== 32'h0) begin bad++; $display("FAIL rstmid_ram_a got=%h want=0", bus.ram_a_o); end
        total++; if (bus.ram_wr_o !== 1'b0) begin bad++; $display("FAIL rstmid_ram_wr got=%b want=0", bus.ram_wr_o); end
        total++; if (bus.ram_dout_o !== 8'h0) begin bad++; $display("FAIL rstmid_dout got=%h want=0", bus.ram_dout_o); end
        total++; if (bus.mem_rdata_o !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h want=0", bus.mem_rdata_o); end
        total++; if (bus.if_inst_o !== 32'h0) begin bad++; $display("FAIL rstmid_inst got=%h want=0", bus.if_inst_o); end
        total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.mem_busy_o); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_done_o) done_seen = 1'b1;
            tick();
        end
        total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done_seen); end
        ref_mem[16'h400] = wd[7:0];
        ref_mem[16'h401] = wd[15:8];
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ram[16'h400 + 16'(i)] !== ref_mem[16'h400 + 16'(i)]) begin
                bad++; $display("FAIL rstmid_byte_%0d got=%h want=%h", i, ram[16'h400 + 16'(i)], ref_mem[16'h400 + 16'(i)]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] inst; int lat; logic tmo;
        logic [31:0] a = 32'hFFFF_FFFE;
        poke(32'hFFFE, 8'h11); poke(32'hFFFF, 8'h22); poke(32'h0000, 8'h33); poke(32'h0001, 8'h44);
        run_fetch(a, inst, lat, tmo);
        total++; if (inst !== 32'h4433_2211) begin bad++; $display("FAIL wrap_inst got=%h want=44332211", inst); end
        total++;
        if (trace_q.size() != 4) begin bad++; $display("FAIL wrap_trace_len got=%0d want=4", trace_q.size()); end
        else for (int k = 0; k < 4; k++) begin
            total++;
            if (trace_q[k] !== a + 32'(k)) begin bad++; $display("FAIL wrap_addr_%0d got=%h want=%h", k, trace_q[k], a + 32'(k)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, a, exp; int lat, wrc, bl, n; logic tmo; logic [1:0] w;
        for (int i = 0; i < 260; i++) poke(32'h1000 + 32'(i), 8'($urandom()));
        for (int t = 0; t < 40; t++) begin
            a = 32'h1000 + $urandom_range(0, 255);
            w = 2'($urandom_range(0, 3));
            wd = $urandom();
            case ($urandom_range(0, 2))
                0: begin
                    exp = ref_read(a, 4);
                    run_fetch(a, rd, lat, tmo);
                    total++; if (tmo || rd !== exp || lat != 4) begin
                        bad++; $display("FAIL rand_fetch_%0d got=%h/%0d want=%h/4", t, rd, lat, exp);
                    end
                end
                1: begin
                    n = nb(w);
                    exp = ref_read(a, n);
                    run_mem(1'b0, w, a, wd, rd, lat, wrc, bl, tmo);
                    total++; if (tmo || rd !== exp || lat != n || wrc != 0 || bl != 0) begin
                        bad++; $display("FAIL rand_load_%0d got=%h/%0d/%0d want=%h/%0d/0", t, rd, lat, wrc, exp, n);
                    end
                end
                default: begin
                    n = nb(w);
                    run_mem(1'b1, w, a, wd, rd, lat, wrc, bl, tmo);
                    for (int k = 0; k < n; k++) ref_mem[16'(a + 32'(k))] = wd[8*k +: 8];
                    total++; if (tmo || lat != n || wrc != n || bl != 0) begin
                        bad++; $display("FAIL rand_store_%0d got=%0d/%0d want=%0d/%0d", t, lat, wrc, n, n);
                    end
                end
            endcase
        end
        for (int i = 0; i < 260; i++) begin
            total++;
            if (ram[16'h1000 + 16'(i)] !== ref_mem[16'h1000 + 16'(i)]) begin
                bad++; $display("FAIL rand_mem_%0d got=%h want=%h", i, ram[16'h1000 + 16'(i)], ref_mem[16'h1000 + 16'(i)]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
        @(negedge clk);
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_cancel();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
